// File: rtl/btb.sv
// -----------------------------------------------------------------------------
// btb : direct-mapped branch target buffer for the fetch-stage PC.
//
// The current fetch PC is looked up combinationally every cycle. A hit is a
// valid entry with a matching tag whose 2-bit direction counter says taken
// (ctr >= 2). Branches and jumps resolved in EX train the table through the
// update port.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   pc           current fetch address (lookup index/tag source)
//   stall_IM_ID  pipeline stall; gates only the hit statistics counter
//   btb_hit      predicted-taken hit for pc (combinational)
//   btb_nxt_pc   predicted target, 16'h0000 when btb_hit = 0
//   upd_en       EX resolved a branch/jump this cycle
//   upd_pc       address of the resolved branch instruction
//   upd_taken    resolved direction, 1 = taken
//   upd_target   resolved target address
//   inval_all    clear every valid bit at the next edge
//   hit_cnt      saturating count of unstalled predicted-taken hits
// -----------------------------------------------------------------------------
module btb #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 16 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        stall_IM_ID,
  output logic        btb_hit,
  output logic [15:0] btb_nxt_pc,
  input  logic        upd_en,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target,
  input  logic        inval_all,
  output logic [15:0] hit_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [15:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t tbl_q [ENTRIES];

  // Lookup side
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  entry_t           rd_entry;

  assign pc_idx = pc[IDX_W-1:0];
  assign pc_tag = pc[15:IDX_W];

  // NOTE: every output of this block gets a default first, so no path
  // through the if leaves a value held and no latch is inferred.
  always_comb begin
    btb_hit    = 1'b0;
    btb_nxt_pc = 16'h0000;
    rd_entry   = tbl_q[pc_idx];
    if (rd_entry.valid && (rd_entry.tag == pc_tag) && rd_entry.ctr[1]) begin
      btb_hit    = 1'b1;
      btb_nxt_pc = rd_entry.target;
    end
  end

  // Update side
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  entry_t           upd_entry;
  logic             upd_resident;

  assign upd_idx      = upd_pc[IDX_W-1:0];
  assign upd_tag      = upd_pc[15:IDX_W];
  assign upd_entry    = tbl_q[upd_idx];
  assign upd_resident = upd_entry.valid && (upd_entry.tag == upd_tag);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge table; that is also what gives lookups in the update cycle
  // the old contents (no write-through).
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table lives in flops, not RAM, so every field is reset to
      // a known value; counters come up weakly not-taken.
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid  <= 1'b0;
        tbl_q[i].tag    <= '0;
        tbl_q[i].target <= 16'h0000;
        tbl_q[i].ctr    <= 2'b01;
      end
    end else if (inval_all) begin
      // Flush drops any simultaneous update and keeps tag/target/ctr.
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
      end
    end else if (upd_en) begin
      if (upd_resident) begin
        if (upd_taken) begin
          if (upd_entry.ctr != 2'b11) tbl_q[upd_idx].ctr <= upd_entry.ctr + 2'b01;
          tbl_q[upd_idx].target <= upd_target;
        end else begin
          if (upd_entry.ctr != 2'b00) tbl_q[upd_idx].ctr <= upd_entry.ctr - 2'b01;
        end
      end else if (upd_taken) begin
        // Allocate weakly taken, evicting whatever aliased here before.
        tbl_q[upd_idx].valid  <= 1'b1;
        tbl_q[upd_idx].tag    <= upd_tag;
        tbl_q[upd_idx].target <= upd_target;
        tbl_q[upd_idx].ctr    <= 2'b10;
      end
    end
  end

  // Statistics: survives inval_all, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= 16'h0000;
    end else if (btb_hit && !stall_IM_ID && (hit_cnt != 16'hFFFF)) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end

endmodule

// File: doc/btb.md
# btb

Direct-mapped branch target buffer feeding the fetch-stage program counter. Each cycle it looks up the current fetch PC combinationally and returns `btb_hit` / `btb_nxt_pc`, which the PC logic uses to redirect fetch in the same cycle. Branches and jumps resolved in EX write back outcome and target through an update port. Each entry carries a 2-bit saturating direction counter.

## Interface
Parameters:
- `IDX_W`, 4: index width; table holds 2^IDX_W entries.
- `TAG_W`, 16-IDX_W: tag width, taken from `pc[15:IDX_W]`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pc`  in  16  current fetch address, the same value driven to instruction memory.
- `stall_IM_ID`  in  1  pipeline stall; gates only the statistics counter.
- `btb_hit`  out  1  predicted-taken hit for `pc` (combinational).
- `btb_nxt_pc`  out  16  predicted target; 16'h0000 when `btb_hit`=0.
- `upd_en`  in  1  EX resolved a branch or jump this cycle. Already qualified upstream: flushed instructions never assert it.
- `upd_pc`  in  16  address of the resolved branch instruction (not PC+1).
- `upd_taken`  in  1  resolved direction; 1 = taken. Jumps always 1.
- `upd_target`  in  16  resolved target address.
- `inval_all`  in  1  clears every valid bit at the next edge.
- `hit_cnt`  out  16  saturating count of unstalled predicted-taken hits.

## Operation
- Entry fields: `valid`, `tag[TAG_W-1:0]`, `target[15:0]`, `ctr[1:0]`. Stored in flops, not RAM.
- Lookup, combinational:
  - idx = `pc[IDX_W-1:0]`.
  - `btb_hit` = valid[idx] && tag[idx]==`pc[15:IDX_W]` && ctr[idx][1].
  - `btb_nxt_pc` = `btb_hit` ? target[idx] : 0.
- Update, on the clock edge when `upd_en`=1:
  - Index the entry with `upd_pc[IDX_W-1:0]`. A tag match (valid and tag equal) is a "resident" entry.
  - Resident and taken: ctr = min(ctr+1, 3); target <= `upd_target`.
  - Resident and not taken: ctr = max(ctr-1, 0); target unchanged. The entry stays valid.
  - Not resident and taken: allocate. Set valid=1, tag, target, ctr=2'b10 (weakly taken). Any prior occupant is overwritten.
  - Not resident and not taken: no change.
- `inval_all`=1: all valid <= 0 at the next edge. It overrides a simultaneous `upd_en`; that update is dropped. Tags, targets and counters are left unchanged.
- `hit_cnt`: increments when `btb_hit` && !`stall_IM_ID`. It saturates at 16'hFFFF and is not cleared by `inval_all`.
- Priority order: `rst` > `inval_all` > `upd_en`.

## Timing
- Reset (`rst`=1 at an edge) sets:
  - all valid=0, ctr=2'b01, target=0, tag=0, `hit_cnt`=0.
  - Consequently `btb_hit`=0 and `btb_nxt_pc`=0 from that edge onward.
- A reset asserted mid-update wins: the pending update is discarded.
- Lookup latency is 0 cycles: the outputs follow `pc` within the same cycle.
- Update latency is 1 cycle:
  - An update at edge N is visible to lookups from cycle N+1.
  - A lookup in the same cycle as an update to the same index sees the pre-update contents. There is no write-through bypass.
- Counter boundaries: 3 + taken stays 3; 0 + not-taken stays 0.
- A hit requires ctr ≥ 2. Entries at ctr 0 or 1 remain resident but report no hit.
- Aliasing: two PCs with equal index and different tags evict each other on taken updates only.
- `stall_IM_ID` does not freeze lookups or updates. EX resolution proceeds independently of fetch stalls.

## Test plan
- Reset then lookup: assert `rst` 1 cycle; sweep `pc` 0x0000–0x000F → `btb_hit`=0, `btb_nxt_pc`=0, `hit_cnt`=0.
- Allocate and hit:
  - Stimulus: `upd_en`=1, `upd_pc`=0x0123, taken, target 0x0200.
  - Next cycle `pc`=0x0123 → `btb_hit`=1, `btb_nxt_pc`=0x0200.
  - `pc`=0x0133 (same index, different tag) → `btb_hit`=0.
- Counter hysteresis, starting from the allocated entry (ctr=2):
  - Stimulus: one not-taken update.
  - Result: `btb_hit`=0 (ctr=1), and no re-allocation on a later taken update (entry is resident).
  - One taken update → `btb_hit`=1 (ctr=2), target refreshed.
  - Saturate at 3, then apply two not-taken updates → hit drops only after the second.
- Same-cycle update/lookup:
  - Stimulus: `pc`=0x0040 while updating 0x0040 taken → 0x0100.
  - Result: `btb_hit`=0 that cycle, 1 with `btb_nxt_pc`=0x0100 the next cycle.
- Priority and flush:
  - Stimulus: `inval_all` and `upd_en` (new taken entry 0x0055) in the same cycle.
  - Result: both 0x0123 and 0x0055 miss afterwards.
  - Repeat with `rst` during `upd_en` → all outputs at reset values.
- Statistics:
  - Hold a hitting `pc` 3 cycles with `stall_IM_ID`=1 on the middle cycle → `hit_cnt`=2.
  - Preload the counter near 0xFFFF via a long run → it saturates at 0xFFFF.
